spi_slave_cu: RTL and testbench

//  SPI responder (slave) for the spi_top master: receives an 8-bit command on MOSI, then returns an 8-bit response on MISO.

---
 rtl/spi_slave_cu_pkg.sv | 26 ++
 rtl/spi_slave_cu_pin_sync.sv | 42 ++++
 rtl/spi_slave_cu.sv | 194 +++++++++++++++++++
 tb/tb_spi_slave_cu.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_cu_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_cu_pkg
// Shared definitions for the SPI responder: FSM state encoding, the latched
// SPI mode record and a helper that picks the sample edge for a mode.
// ---------------------------------------------------------------------------
package spi_slave_cu_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RX   = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_TX   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Clock polarity / phase captured at the start of a frame
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling
  function automatic logic sampleOnRise(input spi_mode_t m);
    return ~(m.cpol ^ m.cpha);
  endfunction

endpackage

// File: rtl/spi_slave_cu_pin_sync.sv
// ---------------------------------------------------------------------------
// spi_slave_cu_pin_sync
// Multi-flop synchronizer for one asynchronous SPI pin, plus rise/fall
// detection on the synchronized level.
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_pin    asynchronous pin
//   o_level  synchronized pin level
//   o_rise   one-cycle pulse on a synchronized 0->1 transition
//   o_fall   one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module spi_slave_cu_pin_sync #(
  parameter int SYNC = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC-1:0] r_sync;
  logic            r_prev;

  // Everything resets low, so a select line already low at reset release
  // never looks like a fresh falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC-2:0], i_pin};
      r_prev <= r_sync[SYNC-1];
    end
  end

  assign o_level = r_sync[SYNC-1];
  assign o_rise  = r_sync[SYNC-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC-1] & r_prev;

endmodule

// File: rtl/spi_slave_cu.sv
// ---------------------------------------------------------------------------
// spi_slave_cu
// SPI responder: receives a DW-bit command on MOSI, then shifts a DW-bit
// response out on MISO. All SPI pins are oversampled on i_clk; SCK is never
// used as a clock. Supports all four CPOL/CPHA modes.
//   i_clk        system clock (>= 8x SCK)
//   i_rst_n      asynchronous active-low reset
//   i_cpol       SCK idle level, latched on select
//   i_cpha       0: sample leading edge, 1: sample trailing edge; latched on select
//   i_sck        serial clock from the master (asynchronous)
//   i_ss_n       slave select, active low (asynchronous)
//   i_mosi       serial data in, MSB first
//   o_miso       serial data out, MSB first; 0 outside the response phase
//   o_rx_data    last received command, held until the next o_rx_valid
//   o_rx_valid   one-cycle pulse: o_rx_data updated
//   i_tx_data    response word, captured the cycle after o_rx_valid
//   o_end_frame  one-cycle pulse: response fully shifted out
//   o_busy       high from select until the block is idle again
//   o_err        one-cycle pulse: select released mid-frame
// ---------------------------------------------------------------------------
module spi_slave_cu
  import spi_slave_cu_pkg::*;
#(
  parameter int DW   = 8,
  parameter int SYNC = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cpol,
  input  logic          i_cpha,
  input  logic          i_sck,
  input  logic          i_ss_n,
  input  logic          i_mosi,
  output logic          o_miso,
  output logic [DW-1:0] o_rx_data,
  output logic          o_rx_valid,
  input  logic [DW-1:0] i_tx_data,
  output logic          o_end_frame,
  output logic          o_busy,
  output logic          o_err
);

  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_ss_level, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;
  logic w_sample, w_launch, w_last_bit;

  logic [2:0]    r_state;
  spi_mode_t     r_mode;
  logic [CW-1:0] r_bitcnt;
  logic [DW-1:0] r_rxsh;
  logic [DW-1:0] r_txsh;
  logic          r_txfirst;
  logic [DW-1:0] r_rx_data;
  logic          r_rx_valid;
  logic          r_end_frame;
  logic          r_err;

  spi_slave_cu_pin_sync #(.SYNC(SYNC)) u_sync_sck (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (i_sck),
    .o_level (w_sck_level),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_slave_cu_pin_sync #(.SYNC(SYNC)) u_sync_ss (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (i_ss_n),
    .o_level (w_ss_level),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  // MOSI passes the same number of stages as SCK, so the synchronized data
  // bit lines up with the synchronized sample edge.
  spi_slave_cu_pin_sync #(.SYNC(SYNC)) u_sync_mosi (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (i_mosi),
    .o_level (w_mosi),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  assign w_unused = w_sck_level ^ w_ss_rise ^ w_mosi_rise ^ w_mosi_fall;

  assign w_sample   = sampleOnRise(r_mode) ? w_sck_rise : w_sck_fall;
  assign w_launch   = sampleOnRise(r_mode) ? w_sck_fall : w_sck_rise;
  assign w_last_bit = (r_bitcnt == CNT_LAST);

  // Frame FSM. The synchronized select level is checked first in every
  // active state, so a deselect always beats a coincident SCK edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= '0;
      r_bitcnt    <= '0;
      r_rxsh      <= '0;
      r_txsh      <= '0;
      r_txfirst   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_end_frame <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_end_frame <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_mode   <= '{cpol: i_cpol, cpha: i_cpha};
            r_bitcnt <= '0;
            r_state  <= ST_RX;
          end
        end
        ST_RX: begin
          if (w_ss_level) begin
            // Select then deselect without any bit clocked is not an error
            r_state <= ST_IDLE;
            r_err   <= (r_bitcnt != '0);
          end else if (w_sample) begin
            r_rxsh   <= {r_rxsh[DW-2:0], w_mosi};
            r_bitcnt <= r_bitcnt + CNT_ONE;
            if (w_last_bit) begin
              r_rx_data  <= {r_rxsh[DW-2:0], w_mosi};
              r_rx_valid <= 1'b1;
              r_state    <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (w_ss_level) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_txsh    <= i_tx_data;
            r_bitcnt  <= '0;
            r_txfirst <= r_mode.cpha;
            r_state   <= ST_TX;
          end
        end
        ST_TX: begin
          if (w_ss_level) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end else if (w_launch) begin
            // CPHA=1: the first launch edge announces the MSB already on MISO.
            // CPHA=0: the trailing edge of the last command bit can land here
            // before any response bit was sampled; shifting then would lose
            // the MSB, so launches are only honoured after a sample.
            if (r_mode.cpha) begin
              if (r_txfirst) begin
                r_txfirst <= 1'b0;
              end else begin
                r_txsh <= {r_txsh[DW-2:0], 1'b0};
              end
            end else if (r_bitcnt != '0) begin
              r_txsh <= {r_txsh[DW-2:0], 1'b0};
            end
          end else if (w_sample) begin
            r_bitcnt <= r_bitcnt + CNT_ONE;
            if (w_last_bit) begin
              r_end_frame <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (w_ss_level) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_miso      = (r_state == ST_TX) & r_txsh[DW-1];
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_end_frame = r_end_frame;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_err       = r_err;

endmodule

// File: tb/tb_spi_slave_cu.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_cu
// Drives SPI master frames (command out, turnaround, response in) into the
// responder in all four modes and scoreboards received commands and the
// returned response bytes.
// ---------------------------------------------------------------------------
module tb_spi_slave_cu;

  localparam int HALF = 80;
  localparam int TURN = 160;
  localparam int GAP  = 320;

  logic       clk = 1'b0;
  logic       rstN;
  logic       cpolPin, cphaPin;
  logic       sck, ssN, mosi;
  logic       miso;
  logic [7:0] rxData;
  logic       rxValid;
  logic [7:0] txData;
  logic       endFrame, busy, err;

  int compareCount  = 0;
  int mismatchCount = 0;
  int rxCount = 0, efCount = 0, errCount = 0;
  int expRx = 0, expEf = 0, expErr = 0;

  logic [7:0] rxExp[$];
  logic [7:0] misoExp[$];

  always #5 clk = ~clk;

  spi_slave_cu #(.DW(8), .SYNC(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_cpol      (cpolPin),
    .i_cpha      (cphaPin),
    .i_sck       (sck),
    .i_ss_n      (ssN),
    .i_mosi      (mosi),
    .o_miso      (miso),
    .o_rx_data   (rxData),
    .o_rx_valid  (rxValid),
    .i_tx_data   (txData),
    .o_end_frame (endFrame),
    .o_busy      (busy),
    .o_err       (err)
  );

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Monitor: pops the expected command whenever the DUT reports one and
  // counts end-of-frame and error pulses
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      if (rxValid === 1'b1) begin
        rxCount++;
        if (rxExp.size() == 0)
          checkOutput("rxUnexpected", rxExp.size(), 1);
        else
          checkOutput("rxData", {24'd0, rxData}, {24'd0, rxExp.pop_front()});
      end
      if (endFrame === 1'b1) efCount++;
      if (err === 1'b1) errCount++;
    end
  end

  // One master frame: rxBits command bits, then txBits response bits
  task automatic applyStimulus(input logic cpol, input logic cpha, input logic [7:0] cmd,
                               input int rxBits, input int txBits, input logic deselect,
                               input logic flipCpha, input int gap);
    logic [7:0] respPre;
    logic [7:0] respPost;
    logic [7:0] expMiso;
    respPre  = 8'h00;
    respPost = 8'h00;
    cpolPin  = cpol;
    cphaPin  = cpha;
    sck      = cpol;
    mosi     = cmd[7];
    #(HALF);
    ssN = 1'b0;
    #(2*HALF);
    checkOutput("busyInFrame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < rxBits; i++) begin
      if (flipCpha && i == 4) cphaPin = ~cpha;
      if (!cpha) begin
        mosi = cmd[7-i];
        #(HALF);
        sck = ~sck;
        #(HALF);
        sck = ~sck;
      end else begin
        sck = ~sck;
        mosi = cmd[7-i];
        #(HALF);
        sck = ~sck;
        #(HALF);
      end
    end
    if (txBits > 0) #(TURN);
    for (int i = 0; i < txBits; i++) begin
      if (!cpha) begin
        respPre = {respPre[6:0], miso};
        sck = ~sck;
        #20;
        respPost = {respPost[6:0], miso};
        #(HALF-20);
        sck = ~sck;
        #(HALF);
      end else begin
        sck = ~sck;
        #(HALF);
        respPre = {respPre[6:0], miso};
        sck = ~sck;
        #20;
        respPost = {respPost[6:0], miso};
        #(HALF-20);
      end
    end
    if (txBits == 8) begin
      expMiso = misoExp.pop_front();
      checkOutput("misoByte", {24'd0, respPre}, {24'd0, expMiso});
      checkOutput("misoHold", {24'd0, respPost}, {24'd0, expMiso});
    end
    if (deselect) begin
      #(HALF);
      ssN = 1'b1;
      #(gap);
    end
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, ".rxCount"}, rxCount, expRx);
    checkOutput({tag, ".endFrames"}, efCount, expEf);
    checkOutput({tag, ".errCount"}, errCount, expErr);
    checkOutput({tag, ".busyIdle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic runFrame(input string tag, input logic cpol, input logic cpha, input logic [7:0] cmd,
                          input logic [7:0] resp, input logic flipCpha, input int gap);
    txData = resp;
    rxExp.push_back(cmd);
    misoExp.push_back(resp);
    expRx++;
    expEf++;
    applyStimulus(cpol, cpha, cmd, 8, 8, 1'b1, flipCpha, gap);
    checkCounts(tag);
  endtask

  initial begin
    rstN = 1'b1;
    ssN = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    cpolPin = 1'b0;
    cphaPin = 1'b0;
    txData = 8'h00;
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("resetMiso", {31'd0, miso}, 32'd0);
    checkOutput("resetRxData", {24'd0, rxData}, 32'd0);
    checkOutput("resetRxValid", {31'd0, rxValid}, 32'd0);
    checkOutput("resetEndFrame", {31'd0, endFrame}, 32'd0);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetErr", {31'd0, err}, 32'd0);
    #20;
    rstN = 1'b1;
    #(GAP);

    $display("[TB] mode 0 frame");
    runFrame("mode0", 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, GAP);

    $display("[TB] modes 1..3");
    runFrame("mode1", 1'b0, 1'b1, 8'h5A, 8'hC3, 1'b0, GAP);
    runFrame("mode2", 1'b1, 1'b0, 8'h5A, 8'hC3, 1'b0, GAP);
    runFrame("mode3", 1'b1, 1'b1, 8'h5A, 8'hC3, 1'b0, GAP);

    $display("[TB] abort after 4 command bits");
    expErr++;
    applyStimulus(1'b0, 1'b0, 8'hA5, 4, 0, 1'b1, 1'b0, GAP);
    checkCounts("abort");
    runFrame("afterAbort", 1'b0, 1'b0, 8'h81, 8'h7E, 1'b0, GAP);

    $display("[TB] reset mid response");
    txData = 8'hFF;
    rxExp.push_back(8'hC6);
    expRx++;
    applyStimulus(1'b0, 1'b0, 8'hC6, 8, 3, 1'b0, 1'b0, 0);
    checkOutput("misoBeforeReset", {31'd0, miso}, 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("misoInReset", {31'd0, miso}, 32'd0);
    checkOutput("busyInReset", {31'd0, busy}, 32'd0);
    #9;
    rstN = 1'b1;
    #(2*HALF);
    for (int i = 0; i < 16; i++) begin
      sck = ~sck;
      #(HALF);
    end
    checkCounts("heldSelect");
    ssN = 1'b1;
    #(GAP);
    runFrame("reselect", 1'b0, 1'b0, 8'h3D, 8'hD3, 1'b0, GAP);

    $display("[TB] back-to-back frames");
    runFrame("b2bFirst", 1'b0, 1'b0, 8'h01, 8'h96, 1'b0, 4*HALF);
    runFrame("b2bSecond", 1'b0, 1'b0, 8'hFF, 8'h69, 1'b0, GAP);

    $display("[TB] CPHA change mid frame");
    runFrame("cphaFlip", 1'b0, 1'b1, 8'hB4, 8'h4B, 1'b1, GAP);
    runFrame("newMode", 1'b0, 1'b0, 8'h2E, 8'hE2, 1'b0, GAP);

    checkOutput("rxPending", rxExp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
